// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between two
// requesters, with a registered issue stage and a per-requester response handshake.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_src1,
    input  logic [N-1:0] req0_src2,
    input  logic [N-1:0] req1_src1,
    input  logic [N-1:0] req1_src2,
    input  logic [2:0]   req0_ctrl,
    input  logic [2:0]   req1_ctrl,
    output logic [N-1:0] alu_src1,
    output logic [N-1:0] alu_src2,
    output logic [2:0]   alu_ctrl_sig,
    input  logic [N-1:0] alu_out,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp0_data,
    output logic [N-1:0] rsp1_data,
    output logic         rsp0_zero,
    output logic         rsp1_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] CtrlReserved = 3'b011;

    state_t       state_q;
    logic         lastGrant_q;
    logic         owner_q;
    logic [N-1:0] src1_q;
    logic [N-1:0] src2_q;
    logic [2:0]   ctrl_q;
    logic [N-1:0] result_q;
    logic         zero_q;
    logic         rsp0Valid_q;
    logic         rsp1Valid_q;
    logic         grant0;
    logic         grant1;
    logic         rspDone;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || lastGrant_q);
        grant1 = req1_valid && (!req0_valid || !lastGrant_q);
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign rspDone = owner_q ? (rsp1Valid_q && rsp1_ready) : (rsp0Valid_q && rsp0_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            ctrl_q      <= 3'b000;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready) begin
                        src1_q      <= req0_src1;
                        src2_q      <= req0_src2;
                        ctrl_q      <= req0_ctrl;
                        owner_q     <= 1'b0;
                        lastGrant_q <= 1'b0;
                        state_q     <= EXEC;
                    end else if (req1_ready) begin
                        src1_q      <= req1_src1;
                        src2_q      <= req1_src2;
                        ctrl_q      <= req1_ctrl;
                        owner_q     <= 1'b1;
                        lastGrant_q <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    // The reserved code never trusts the ALU and always yields zero.
                    if (ctrl_q == CtrlReserved) begin
                        result_q <= '0;
                        zero_q   <= 1'b1;
                    end else begin
                        result_q <= alu_out;
                        zero_q   <= (alu_out == '0);
                    end
                    rsp0Valid_q <= !owner_q;
                    rsp1Valid_q <= owner_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rspDone) begin
                        rsp0Valid_q <= 1'b0;
                        rsp1Valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_src1     = src1_q;
    assign alu_src2     = src2_q;
    assign alu_ctrl_sig = ctrl_q;
    assign rsp0_valid   = rsp0Valid_q;
    assign rsp1_valid   = rsp1Valid_q;
    assign rsp0_data    = result_q;
    assign rsp1_data    = result_q;
    assign rsp0_zero    = zero_q;
    assign rsp1_zero    = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level reference model; the bench also plays the shared ALU.
module tb_alu_arbiter;
    localparam int N = 8;

    bit           clk = 1'b0;
    logic         reset;
    logic         req0Valid, req1Valid;
    logic         req0Ready, req1Ready;
    logic [N-1:0] req0Src1, req0Src2, req1Src1, req1Src2;
    logic [2:0]   req0Ctrl, req1Ctrl;
    logic [N-1:0] aluSrc1, aluSrc2, aluOut;
    logic [2:0]   aluCtrl;
    logic         rsp0Valid, rsp1Valid, rsp0Ready, rsp1Ready;
    logic [N-1:0] rsp0Data, rsp1Data;
    logic         rsp0Zero, rsp1Zero;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one outstanding operation, its age in cycles, and its result.
    bit           modelArmed = 1'b0;
    bit           modelBusy  = 1'b0;
    bit           modelLast  = 1'b1;
    bit           modelOwner = 1'b0;
    int           modelAge   = 0;
    logic [N-1:0] modelResult = '0;
    logic [N-1:0] modelSrc1 = '0;
    logic [N-1:0] modelSrc2 = '0;
    logic [2:0]   modelCtrl = 3'b000;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0Valid),
        .req1_valid  (req1Valid),
        .req0_ready  (req0Ready),
        .req1_ready  (req1Ready),
        .req0_src1   (req0Src1),
        .req0_src2   (req0Src2),
        .req1_src1   (req1Src1),
        .req1_src2   (req1Src2),
        .req0_ctrl   (req0Ctrl),
        .req1_ctrl   (req1Ctrl),
        .alu_src1    (aluSrc1),
        .alu_src2    (aluSrc2),
        .alu_ctrl_sig(aluCtrl),
        .alu_out     (aluOut),
        .rsp0_valid  (rsp0Valid),
        .rsp1_valid  (rsp1Valid),
        .rsp0_ready  (rsp0Ready),
        .rsp1_ready  (rsp1Ready),
        .rsp0_data   (rsp0Data),
        .rsp1_data   (rsp1Data),
        .rsp0_zero   (rsp0Zero),
        .rsp1_zero   (rsp1Zero)
    );

    function automatic logic [N-1:0] refOp(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] c);
        case (c)
            3'b000:         return a & b;
            3'b001:         return a | b;
            3'b010:         return a + b;
            3'b100:         return a & ~b;
            3'b101, 3'b110: return a | ~b;
            3'b111:         return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
            default:        return N'(0);
        endcase
    endfunction

    // The shared ALU returns garbage for the reserved code so the arbiter must ignore it.
    function automatic logic [N-1:0] aluModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [2:0] c);
        if (c == 3'b011) return (a ^ b) | N'(1);
        return refOp(a, b, c);
    endfunction

    assign aluOut = aluModel(aluSrc1, aluSrc2, aluCtrl);

    function automatic int pickGrant(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v0, input bit v1, input bit r0, input bit r1);
        req0Valid = v0;
        req1Valid = v1;
        rsp0Ready = r0;
        rsp1Ready = r1;
    endtask

    task automatic setReq(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2:0] c);
        if (k == 0) begin
            req0Src1 = a; req0Src2 = b; req0Ctrl = c;
        end else begin
            req1Src1 = a; req1Src2 = b; req1Ctrl = c;
        end
    endtask

    task automatic modelStep();
        int g;
        if (reset) begin
            modelBusy   = 1'b0;
            modelLast   = 1'b1;
            modelOwner  = 1'b0;
            modelAge    = 0;
            modelResult = '0;
            modelSrc1   = '0;
            modelSrc2   = '0;
            modelCtrl   = 3'b000;
            modelArmed  = 1'b1;
        end else if (!modelBusy) begin
            g = pickGrant(req0Valid, req1Valid, modelLast);
            if (g >= 0) begin
                modelBusy   = 1'b1;
                modelAge    = 0;
                modelOwner  = (g == 1);
                modelLast   = (g == 1);
                modelSrc1   = (g == 1) ? req1Src1 : req0Src1;
                modelSrc2   = (g == 1) ? req1Src2 : req0Src2;
                modelCtrl   = (g == 1) ? req1Ctrl : req0Ctrl;
                modelResult = refOp(modelSrc1, modelSrc2, modelCtrl);
            end
        end else if (modelAge >= 1 && (modelOwner ? rsp1Ready : rsp0Ready)) begin
            modelBusy = 1'b0;
        end else if (modelAge < 2) begin
            modelAge++;
        end
    endtask

    task automatic checkAll();
        int g;
        bit e0;
        bit e1;
        g  = pickGrant(req0Valid, req1Valid, modelLast);
        e0 = modelBusy && modelAge >= 1 && !modelOwner;
        e1 = modelBusy && modelAge >= 1 && modelOwner;
        checkOutput("req0_ready", 32'(req0Ready), 32'(!modelBusy && g == 0));
        checkOutput("req1_ready", 32'(req1Ready), 32'(!modelBusy && g == 1));
        checkOutput("rsp0_valid", 32'(rsp0Valid), 32'(e0));
        checkOutput("rsp1_valid", 32'(rsp1Valid), 32'(e1));
        if (e0) begin
            checkOutput("rsp0_data", 32'(rsp0Data), 32'(modelResult));
            checkOutput("rsp0_zero", 32'(rsp0Zero), 32'(modelResult == '0));
        end
        if (e1) begin
            checkOutput("rsp1_data", 32'(rsp1Data), 32'(modelResult));
            checkOutput("rsp1_zero", 32'(rsp1Zero), 32'(modelResult == '0));
        end
        checkOutput("alu_src1", 32'(aluSrc1), 32'(modelSrc1));
        checkOutput("alu_src2", 32'(aluSrc2), 32'(modelSrc2));
        checkOutput("alu_ctrl_sig", 32'(aluCtrl), 32'(modelCtrl));
    endtask

    // Model advances on the same edge as the DUT; inputs only move 1ns after edges.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every falling edge compares the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelArmed) checkAll();
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 1, 1);
        setReq(0, '0, '0, 3'b000);
        setReq(1, '0, '0, 3'b000);
        tick();
        tick();
        checkOutput("reset_rsp0_valid", 32'(rsp0Valid), 32'd0);
        checkOutput("reset_rsp1_valid", 32'(rsp1Valid), 32'd0);
        checkOutput("reset_alu_ctrl", 32'(aluCtrl), 32'd0);
        checkOutput("reset_alu_src1", 32'(aluSrc1), 32'd0);
        checkOutput("reset_rsp0_data", 32'(rsp0Data), 32'd0);
        reset = 1'b0;

        // Single ADD 5+3 from requester 0.
        setReq(0, 8'd5, 8'd3, 3'b010);
        applyStimulus(1, 0, 1, 1);
        #1;
        checkOutput("single_req0_ready", 32'(req0Ready), 32'd1);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("single_exec_valid", 32'(rsp0Valid), 32'd0);
        checkOutput("single_alu_src1", 32'(aluSrc1), 32'd5);
        checkOutput("single_alu_ctrl", 32'(aluCtrl), 32'd2);
        tick();
        checkOutput("single_rsp0_valid", 32'(rsp0Valid), 32'd1);
        checkOutput("single_rsp0_data", 32'(rsp0Data), 32'd8);
        checkOutput("single_rsp0_zero", 32'(rsp0Zero), 32'd0);
        tick();
        checkOutput("single_done_valid", 32'(rsp0Valid), 32'd0);

        // Tie from reset: req0 first, then req1, then req0 again.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setReq(0, 8'hF0, 8'h0F, 3'b000);
        setReq(1, 8'd2, 8'd7, 3'b111);
        applyStimulus(1, 1, 1, 1);
        #1;
        checkOutput("tie_req0_ready", 32'(req0Ready), 32'd1);
        checkOutput("tie_req1_ready", 32'(req1Ready), 32'd0);
        tick();
        tick();
        checkOutput("tie_rsp0_valid", 32'(rsp0Valid), 32'd1);
        checkOutput("tie_rsp1_quiet", 32'(rsp1Valid), 32'd0);
        checkOutput("tie_rsp0_data", 32'(rsp0Data), 32'd0);
        checkOutput("tie_rsp0_zero", 32'(rsp0Zero), 32'd1);
        tick();
        checkOutput("tie2_req1_ready", 32'(req1Ready), 32'd1);
        checkOutput("tie2_req0_ready", 32'(req0Ready), 32'd0);
        tick();
        tick();
        checkOutput("tie_rsp1_valid", 32'(rsp1Valid), 32'd1);
        checkOutput("tie_rsp1_data", 32'(rsp1Data), 32'd1);
        checkOutput("tie_rsp1_zero", 32'(rsp1Zero), 32'd0);
        tick();
        checkOutput("tie3_req0_ready", 32'(req0Ready), 32'd1);
        checkOutput("tie3_req1_ready", 32'(req1Ready), 32'd0);
        applyStimulus(0, 0, 1, 1);

        // Backpressure on requester 1 for ten cycles.
        setReq(1, 8'h30, 8'h03, 3'b001);
        applyStimulus(0, 1, 1, 0);
        tick();
        applyStimulus(1, 1, 1, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_rsp1_valid", 32'(rsp1Valid), 32'd1);
            checkOutput("bp_rsp1_data", 32'(rsp1Data), 32'h33);
            checkOutput("bp_req0_ready", 32'(req0Ready), 32'd0);
            checkOutput("bp_req1_ready", 32'(req1Ready), 32'd0);
            tick();
        end
        applyStimulus(1, 0, 1, 1);
        tick();
        checkOutput("bp_release_valid", 32'(rsp1Valid), 32'd0);
        checkOutput("bp_release_idle", 32'(req0Ready), 32'd1);
        applyStimulus(0, 0, 1, 1);

        // Reserved code: ALU output is nonzero but the response must be zero.
        setReq(0, 8'd9, 8'd4, 3'b011);
        applyStimulus(1, 0, 1, 1);
        tick();
        applyStimulus(0, 0, 1, 1);
        tick();
        checkOutput("rsv_rsp0_valid", 32'(rsp0Valid), 32'd1);
        checkOutput("rsv_rsp0_data", 32'(rsp0Data), 32'd0);
        checkOutput("rsv_rsp0_zero", 32'(rsp0Zero), 32'd1);
        tick();

        // Reset while a response is pending, colliding with the handshake.
        setReq(1, 8'd1, 8'd1, 3'b010);
        applyStimulus(0, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        tick();
        checkOutput("rstresp_pending", 32'(rsp1Valid), 32'd1);
        reset = 1'b1;
        rsp1Ready = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstresp_rsp0_valid", 32'(rsp0Valid), 32'd0);
        checkOutput("rstresp_rsp1_valid", 32'(rsp1Valid), 32'd0);
        checkOutput("rstresp_alu_ctrl", 32'(aluCtrl), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rstresp_no_stale", 32'(rsp1Valid), 32'd0);
        end

        // Back-to-back 0xFF+0x01 on requester 0: one accept every three cycles.
        setReq(0, 8'hFF, 8'h01, 3'b010);
        applyStimulus(1, 0, 1, 1);
        #1;
        for (int i = 0; i < 9; i++) begin
            checkOutput("b2b_req0_ready", 32'(req0Ready), 32'(i % 3 == 0));
            checkOutput("b2b_rsp0_valid", 32'(rsp0Valid), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                checkOutput("b2b_rsp0_data", 32'(rsp0Data), 32'd0);
                checkOutput("b2b_rsp0_zero", 32'(rsp0Zero), 32'd1);
            end
            tick();
        end
        applyStimulus(0, 0, 1, 1);
        tick();
        tick();

        // Random traffic with occasional resets; the model does the checking.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            setReq(0, N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
            setReq(1, N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) req0Src2 = req0Src1;
            tick();
        end
        reset = 1'b0;
        applyStimulus(0, 0, 1, 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
